transpose_stream: RTL and testbench

- Streaming, double-buffered matrix transposer for the fetal ECG datapath.
- Accepts a SIZE_A x SIZE_B matrix one element per cycle in row-major order and emits it in the order selected per matrix:
  - transposed: row-major order of the SIZE_B x SIZE_A transpose;
  - pass-through: original row-major order.
- Two banks (ping-pong) let one matrix be written while the previous one drains, so back-to-back matrices stream with no stall.
- Sits between the serial sample/whitening pipeline and the matrix-multiply stages.

---
 rtl/fecg_mat_pkg.sv | 23 ++
 rtl/transpose_stream_if.sv | 27 ++
 rtl/mat_bank.sv | 34 +++
 rtl/transpose_stream.sv | 182 ++++++++++++++++++
 tb/tb_transpose_stream.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fecg_mat_pkg.sv
// Shared types and constants for the fetal-ECG matrix stages.
package fecg_mat_pkg;

    localparam int ELEM_BITS = 22;

    typedef logic [ELEM_BITS-1:0] element_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    localparam logic MODE_PASS      = 1'b0;
    localparam logic MODE_TRANSPOSE = 1'b1;

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transpose_stream_if.sv
// Element stream in, element stream out, plus the sticky framing error.
interface transpose_stream_if #(
    parameter int N_BITS = 22
) ();

    logic [N_BITS-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              in_mode;
    logic [N_BITS-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              err;

    modport master (
        output in_data, in_valid, in_last, in_mode, out_ready,
        input  in_ready, out_data, out_valid, out_last, err
    );

    modport slave (
        input  in_data, in_valid, in_last, in_mode, out_ready,
        output in_ready, out_data, out_valid, out_last, err
    );

endinterface

// File: rtl/mat_bank.sv
// One SIZE_A x SIZE_B element store: registered write, combinational read.
module mat_bank
    import fecg_mat_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 22,
    localparam int RW = idx_bits(SIZE_A),
    localparam int CW = idx_bits(SIZE_B)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RW-1:0]     wr_row,
    input  logic [CW-1:0]     wr_col,
    input  logic [N_BITS-1:0] wr_data,
    input  logic [RW-1:0]     rd_row,
    input  logic [CW-1:0]     rd_col,
    output logic [N_BITS-1:0] rd_data
);

    logic [N_BITS-1:0] mem [SIZE_A][SIZE_B];

    // NOTE: the array has no reset; the controller's bank state gates every read,
    // so stale contents are never presented and the flops stay reset-free.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/transpose_stream.sv
// Ping-pong matrix transposer: row-major in, transposed or pass-through out.
module transpose_stream
    import fecg_mat_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 22
) (
    input logic               clk,
    input logic               rst,
    transpose_stream_if.slave bus
);

    localparam int RW = idx_bits(SIZE_A);
    localparam int CW = idx_bits(SIZE_B);
    localparam logic [RW-1:0] ROW_MAX = RW'(SIZE_A - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(SIZE_B - 1);

    bank_state_t       state_q [2];
    bank_state_t       state_d [2];
    logic              mode_q  [2];
    logic              mode_d  [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [RW-1:0]     wr_row_q, wr_row_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic [RW-1:0]     rd_row_q, rd_row_d;
    logic [CW-1:0]     rd_col_q, rd_col_d;
    logic [N_BITS-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;

    logic              wr_accept, wr_first, wr_final;
    logic              rd_avail, rd_load, rd_final, rd_bypass, rd_transpose;
    logic [1:0]        bank_we;
    logic [N_BITS-1:0] bank_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        mat_bank #(
            .SIZE_A (SIZE_A),
            .SIZE_B (SIZE_B),
            .N_BITS (N_BITS)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[g]),
            .wr_row  (wr_row_q),
            .wr_col  (wr_col_q),
            .wr_data (bus.in_data),
            .rd_row  (rd_row_q),
            .rd_col  (rd_col_q),
            .rd_data (bank_rdata[g])
        );
    end

    assign bus.in_ready  = (state_q[wr_sel_q] == EMPTY) || (state_q[wr_sel_q] == FILLING);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;

    assign wr_accept    = bus.in_valid && bus.in_ready;
    assign wr_first     = (wr_row_q == '0) && (wr_col_q == '0);
    assign wr_final     = (wr_row_q == ROW_MAX) && (wr_col_q == COL_MAX);
    assign bank_we[0]   = wr_accept && !wr_sel_q;
    assign bank_we[1]   = wr_accept && wr_sel_q;

    // A bank completing this cycle may already be the read bank; loading its
    // element 0 now gives first out_valid one cycle after the final accept.
    assign rd_avail     = (state_q[rd_sel_q] == FULL) || (state_q[rd_sel_q] == DRAINING)
                          || (wr_accept && wr_final && (wr_sel_q == rd_sel_q));
    assign rd_load      = (!out_valid_q || bus.out_ready) && rd_avail;
    assign rd_final     = (rd_row_q == ROW_MAX) && (rd_col_q == COL_MAX);
    assign rd_bypass    = wr_accept && (wr_sel_q == rd_sel_q)
                          && (wr_row_q == rd_row_q) && (wr_col_q == rd_col_q);
    assign rd_transpose = (mode_q[rd_sel_q] == MODE_TRANSPOSE);

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = err_q;

        if (wr_accept) begin
            if (wr_first) begin
                mode_d[wr_sel_q] = bus.in_mode;
            end
            if (bus.in_last != wr_final) begin
                err_d = 1'b1;
            end
            if (wr_final) begin
                state_d[wr_sel_q] = FULL;
                wr_sel_d          = !wr_sel_q;
                wr_row_d          = '0;
                wr_col_d          = '0;
            end else begin
                state_d[wr_sel_q] = FILLING;
                if (wr_col_q == COL_MAX) begin
                    wr_col_d = '0;
                    wr_row_d = wr_row_q + 1'b1;
                end else begin
                    wr_col_d = wr_col_q + 1'b1;
                end
            end
        end

        // Read-side update comes second so an early load overrides FULL with DRAINING.
        if (rd_load) begin
            out_data_d  = rd_bypass ? bus.in_data : bank_rdata[rd_sel_q];
            out_valid_d = 1'b1;
            out_last_d  = rd_final;
            if (rd_final) begin
                state_d[rd_sel_q] = EMPTY;
                rd_sel_d          = !rd_sel_q;
                rd_row_d          = '0;
                rd_col_d          = '0;
            end else begin
                state_d[rd_sel_q] = DRAINING;
                if (rd_transpose) begin
                    if (rd_row_q == ROW_MAX) begin
                        rd_row_d = '0;
                        rd_col_d = rd_col_q + 1'b1;
                    end else begin
                        rd_row_d = rd_row_q + 1'b1;
                    end
                end else begin
                    if (rd_col_q == COL_MAX) begin
                        rd_col_d = '0;
                        rd_row_d = rd_row_q + 1'b1;
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            mode_q[0]   <= MODE_PASS;
            mode_q[1]   <= MODE_PASS;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_transpose_stream.sv
// Self-checking bench for transpose_stream on a 2x3 matrix with a queue-based reference model.
module tb_transpose_stream;
    import fecg_mat_pkg::*;

    localparam int A  = 2;
    localparam int B  = 3;
    localparam int NB = ELEM_BITS;
    localparam int NE = A * B;
    localparam int NM = 20;

    typedef struct packed {
        element_t data;
        logic     last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    transpose_stream_if #(.N_BITS(NB)) bus ();

    transpose_stream #(
        .SIZE_A (A),
        .SIZE_B (B),
        .N_BITS (NB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int       checks   = 0;
    int       failures = 0;
    exp_t     exp_q [$];
    element_t seen  [$];
    element_t cur   [NE];
    int       cnt        = 0;
    logic     cur_mode   = 1'b0;
    logic     err_exp    = 1'b0;
    bit       hold_ok    = 1'b0;
    element_t prev_data  = '0;
    logic     prev_last  = 1'b0;
    bit       watch_ready = 1'b0;
    int       ready_drops = 0;
    bit       done        = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: collect a whole matrix, then emit it in index order.
    always @(negedge clk) begin
        check("err", bus.err, err_exp);
        if (rst) begin
            exp_q.delete();
            cnt     = 0;
            err_exp = 1'b0;
            hold_ok = 1'b0;
        end else begin
            if (hold_ok) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_last", bus.out_last, e.last);
                    seen.push_back(bus.out_data);
                end
            end
            hold_ok   = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_last = bus.out_last;
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_last != (cnt == NE - 1)) err_exp = 1'b1;
                if (cnt == 0) cur_mode = bus.in_mode;
                cur[cnt] = bus.in_data;
                cnt++;
                if (cnt == NE) begin
                    for (int k = 0; k < NE; k++) begin
                        int r, c;
                        if (cur_mode) begin
                            r = k % A;
                            c = k / A;
                        end else begin
                            r = k / B;
                            c = k % B;
                        end
                        exp_q.push_back('{data: cur[r * B + c], last: (k == NE - 1)});
                    end
                    cnt = 0;
                end
            end
            if (watch_ready && !bus.in_ready) ready_drops++;
        end
    end

    task automatic send_elem(input element_t d, input logic last, input logic mode);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_mode  = mode;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("accept_timeout", 0, 1);
        end
    endtask

    task automatic send_matrix(input int base, input logic mode, input int last_pos);
        for (int i = 0; i < NE; i++) begin
            send_elem(element_t'(base + i), (i == last_pos), mode);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_seen(input string name, input int vals[$]);
        check({name, "_count"}, seen.size(), vals.size());
        for (int i = 0; i < vals.size() && i < seen.size(); i++) begin
            check($sformatf("%s_%0d", name, i), seen[i], vals[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit [$];
        int idx;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Transposed 2x3, first output one cycle after final accept
        seen.delete();
        send_matrix(0, MODE_TRANSPOSE, NE - 1);
        check("latency_valid", bus.out_valid, 1);
        check("latency_data", bus.out_data, 0);
        wait_drain();
        lit = {0, 3, 1, 4, 2, 5};
        check_seen("t_transpose", lit);

        // Pass-through
        seen.delete();
        send_matrix(0, MODE_PASS, NE - 1);
        wait_drain();
        lit = {0, 1, 2, 3, 4, 5};
        check_seen("t_pass", lit);

        // Back-to-back, alternating modes
        seen.delete();
        ready_drops = 0;
        watch_ready = 1'b1;
        send_matrix(0, MODE_TRANSPOSE, NE - 1);
        send_matrix(10, MODE_PASS, NE - 1);
        send_matrix(20, MODE_TRANSPOSE, NE - 1);
        watch_ready = 1'b0;
        wait_drain();
        check("b2b_ready_drops", ready_drops, 0);
        lit = {0, 3, 1, 4, 2, 5, 10, 11, 12, 13, 14, 15, 20, 23, 21, 24, 22, 25};
        check_seen("t_b2b", lit);

        // Output stalled: both banks fill, then in_ready drops
        seen.delete();
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (idx < 18) begin
                bus.in_valid = 1'b1;
                bus.in_data  = element_t'((idx / NE) * 10 + idx % NE);
                bus.in_last  = (idx % NE == NE - 1);
                bus.in_mode  = MODE_TRANSPOSE;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("stall_accepted", idx, 12);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_out_data", bus.out_data, 0);
        bus.out_ready = 1'b1;
        wait_drain();
        lit = {0, 3, 1, 4, 2, 5, 10, 13, 11, 14, 12, 15};
        check_seen("t_stall", lit);

        // Early in_last: sticky error, order unaffected
        seen.delete();
        check("err_before", bus.err, 0);
        send_matrix(30, MODE_TRANSPOSE, 2);
        check("err_set", bus.err, 1);
        wait_drain();
        send_matrix(40, MODE_PASS, NE - 1);
        wait_drain();
        check("err_sticky", bus.err, 1);
        lit = {30, 33, 31, 34, 32, 35, 40, 41, 42, 43, 44, 45};
        check_seen("t_err", lit);

        // Reset mid-matrix, then a fresh matrix
        for (int i = 0; i < 3; i++) send_elem(element_t'(50 + i), 1'b0, MODE_PASS);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        seen.delete();
        send_matrix(0, MODE_TRANSPOSE, NE - 1);
        check("mid_rst_latency", bus.out_valid, 1);
        wait_drain();
        lit = {0, 3, 1, 4, 2, 5};
        check_seen("t_mid_rst", lit);

        // Randomized traffic with input gaps and output back-pressure
        seen.delete();
        done = 1'b0;
        fork
            begin
                for (int m = 0; m < NM; m++) begin
                    logic mode;
                    mode = logic'($urandom_range(0, 1));
                    for (int i = 0; i < NE; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            bus.in_valid = 1'b0;
                            repeat ($urandom_range(1, 3)) @(posedge clk);
                            #1;
                        end
                        send_elem(element_t'($urandom), (i == NE - 1), mode);
                    end
                end
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        check("random_count", seen.size(), NM * NE);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_err", bus.err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
